// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// board clock/baud constants shared with uart_tx, and a pointer-width helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB       = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } arb_state_e;

    localparam int unsigned CLK_HZ       = 12_000_000;
    localparam int unsigned BAUD         = 115_200;
    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;

    // A single requester still needs a one-bit pointer.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first requester strictly
// after ptr_i (wrapping), returning it one-hot and as an index.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned PTR_W = ptr_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    int cand;

    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand   = 0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = (int'(ptr_i) + k) % int'(N_REQ);
            if (!any_o && req_i[cand]) begin
                pick_o[cand] = 1'b1;
                idx_o        = PTR_W'(cand);
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between N_REQ byte
// sources; each byte is sequenced through the start/busy handshake with retry.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned RESP_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               tx_start,
    output logic [7:0]         tx_data,
    input  logic               tx_busy
);

    localparam int unsigned      PTR_W     = ptr_w(N_REQ);
    localparam int unsigned      CNT_W     = $clog2(RESP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_RETRY = CNT_W'(RESP_TIMEOUT - 1);

    arb_state_e       state_q,  state_d;
    logic [N_REQ-1:0] grant_q,  grant_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       data_q,   data_d;
    logic             last_q,   last_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic [N_REQ-1:0] pick;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i  (req_valid),
        .ptr_i  (rr_ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Grant is one-hot, so OR-ing the masked lanes is a plain mux.
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_q[i]) begin
                sel_data = sel_data | req_data[8*i +: 8];
                sel_last = sel_last | req_last[i];
            end
        end
    end

    assign req_ready = (state_q == LOAD) ? (grant_q & {N_REQ{~tx_busy}}) : '0;
    assign accept    = |(req_valid & req_ready);
    assign grant     = grant_q;
    assign tx_start  = (state_q == START);
    assign tx_data   = data_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ARB: begin
                if (pick_any) begin
                    grant_d  = pick;
                    rr_ptr_d = pick_idx;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    data_d  = sel_data;
                    last_d  = sel_last;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    // Re-pulse lands exactly RESP_TIMEOUT clocks after the previous one.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_RETRY) begin
                        state_d = START;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = ARB;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            grant_q  <= '0;
            rr_ptr_q <= PTR_W'(N_REQ - 1);
            data_q   <= 8'h00;
            last_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            data_q   <= data_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte sources, a behavioural uart_tx stub and a
// packet-level round-robin reference model predicting the on-line byte order.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int RT = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy;

    uart_tx_arbiter #(
        .N_REQ        (N),
        .RESP_TIMEOUT (RT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .grant     (grant),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    int total;
    int bad;

    // Source byte buffers: bit 8 is the last flag.
    logic [8:0] sbuf [N][256];
    int         head [N];
    int         tail [N];
    int         hold [N];
    bit         in_pkt [N];
    int         gap_pct;
    logic [N-1:0] prev_acc;

    // uart_tx stub state
    int          cyc;
    int          busy_left;
    int          busy_min;
    int          busy_max;
    bit          ignore_next;
    bit          cur_live;
    logic [7:0]  cur_byte;
    int          pulse_cnt;
    int          pulse_t [$];
    logic [11:0] sent_q [$];
    logic        stub_st;
    logic [7:0]  stub_d;
    logic [N-1:0] stub_g;

    // Reference model
    int          m_ptr;
    logic [11:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (head[i] < tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        bit pend;
        bit gap;
        for (int i = 0; i < N; i++) begin
            pend = head[i] < tail[i];
            gap  = in_pkt[i] && (hold[i] > 0 || int'($urandom_range(99)) < gap_pct);
            req_valid[i]       = pend && !gap;
            req_data[8*i +: 8] = pend ? sbuf[i][head[i]][7:0] : 8'($urandom);
            req_last[i]        = pend ? sbuf[i][head[i]][8] : 1'b0;
        end
    endtask

    task automatic push_byte(input int s, input logic [7:0] b, input bit last);
        sbuf[s][tail[s]] = {last, b};
        tail[s]++;
    endtask

    task automatic clear_bufs();
        for (int i = 0; i < N; i++) begin
            head[i]   = 0;
            tail[i]   = 0;
            hold[i]   = 0;
            in_pkt[i] = 1'b0;
        end
        drive();
    endtask

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        if (rst_n) begin
            check_eq("grant_onehot", 32'($onehot0(grant)), 32'd1);
            check_eq("ready_gated", 32'(req_ready & ~(grant & {N{~tx_busy}})), 32'd0);
            if (|prev_acc) check_eq("start_latency", 32'(tx_start), 32'd1);
        end
        prev_acc = acc;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hold[i] > 0) hold[i]--;
            if (acc[i]) begin
                in_pkt[i] = !sbuf[i][head[i]][8];
                head[i]++;
            end
        end
        drive();
    endtask

    task automatic begin_batch();
        sent_q.delete();
        pulse_t.delete();
        pulse_cnt = 0;
    endtask

    // Whole packets in round-robin order over sources holding queued packets.
    task automatic build_expected();
        int  mh [N];
        int  s;
        bit  found;
        exp_q.delete();
        for (int i = 0; i < N; i++) mh[i] = head[i];
        do begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                s = (m_ptr + k) % N;
                if (!found && mh[s] < tail[s]) begin
                    found = 1'b1;
                    m_ptr = s;
                    do begin
                        exp_q.push_back({4'(s), sbuf[s][mh[s]][7:0]});
                        mh[s]++;
                    end while (!sbuf[s][mh[s]-1][8]);
                end
            end
        end while (found);
    endtask

    task automatic drain_and_compare(input string tag);
        int guard = 0;
        while ((pending() || tx_busy || grant != '0) && guard < 20000) begin
            step();
            guard++;
        end
        repeat (2) step();
        check_eq({tag, "_drained"}, 32'(guard < 20000), 32'd1);
        check_eq({tag, "_count"}, 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            check_eq({tag, "_byte"}, 32'(sent_q[i]), 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        cur_live = 1'b0;
        prev_acc = '0;
        clear_bufs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = N - 1;
    endtask

    // Behavioural uart_tx: busy rises the cycle after start and holds a random span.
    initial begin
        tx_busy   = 1'b0;
        busy_left = 0;
        cyc       = 0;
        forever begin
            @(negedge clk);
            cyc++;
            stub_st = tx_start;
            stub_d  = tx_data;
            stub_g  = grant;
            if (stub_st) begin
                pulse_cnt++;
                pulse_t.push_back(cyc);
            end
            if (cur_live && tx_busy) check_eq("tx_data_stable", 32'(stub_d), 32'(cur_byte));
            @(posedge clk);
            #1;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy  = 1'b0;
                    cur_live = 1'b0;
                end
            end else if (stub_st) begin
                if (ignore_next) begin
                    ignore_next = 1'b0;
                end else begin
                    tx_busy   = 1'b1;
                    busy_left = int'($urandom_range(busy_max, busy_min));
                    cur_byte  = stub_d;
                    cur_live  = 1'b1;
                    sent_q.push_back({4'(onehot_idx(stub_g)), stub_d});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        gap_pct     = 0;
        busy_min    = 3;
        busy_max    = 3;
        ignore_next = 1'b0;
        cur_live    = 1'b0;
        prev_acc    = '0;
        pulse_cnt   = 0;
        m_ptr       = N - 1;
        clear_bufs();

        // Reset state and long idle
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_tx_start", 32'(tx_start), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin_batch();
        repeat (1000) step();
        check_eq("idle_grant", 32'(grant), 32'd0);
        check_eq("idle_pulses", 32'(pulse_cnt), 32'd0);

        // "Hi\n" from source 0 at real bit timing
        busy_min = uart_tx_arbiter_pkg::CLKS_PER_BIT * 10;
        busy_max = busy_min;
        clear_bufs();
        push_byte(0, 8'h48, 1'b0);
        push_byte(0, 8'h69, 1'b0);
        push_byte(0, 8'h0A, 1'b1);
        drive();
        begin_batch();
        build_expected();
        drain_and_compare("hi");
        check_eq("hi_pulses", 32'(pulse_cnt), 32'd3);
        check_eq("hi_grant_released", 32'(grant), 32'd0);

        // Two sources, two 2-byte packets each, from reset: rotation
        busy_min = 2;
        busy_max = 6;
        do_reset();
        push_byte(0, 8'hA0, 1'b0); push_byte(0, 8'hA1, 1'b1);
        push_byte(0, 8'hA2, 1'b0); push_byte(0, 8'hA3, 1'b1);
        push_byte(1, 8'hB0, 1'b0); push_byte(1, 8'hB1, 1'b1);
        push_byte(1, 8'hB2, 1'b0); push_byte(1, 8'hB3, 1'b1);
        drive();
        begin_batch();
        build_expected();
        drain_and_compare("rot");
        check_eq("rot_pulses", 32'(pulse_cnt), 32'd8);

        // Source 1 stalls mid-packet; source 0 must wait for its last byte
        busy_min = 3;
        busy_max = 3;
        clear_bufs();
        begin_batch();
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h12, 1'b1);
        drive();
        guard = 0;
        while (!in_pkt[1] && guard < 100) begin
            step();
            guard++;
        end
        check_eq("stall_first_accept", 32'(in_pkt[1]), 32'd1);
        hold[1] = 500;
        push_byte(0, 8'h21, 1'b0);
        push_byte(0, 8'h22, 1'b1);
        drive();
        repeat (250) step();
        check_eq("stall_grant_kept", 32'(grant), 32'b010);
        check_eq("stall_sent_so_far", 32'(sent_q.size()), 32'd1);
        exp_q.delete();
        exp_q.push_back({4'd1, 8'h11});
        exp_q.push_back({4'd1, 8'h12});
        exp_q.push_back({4'd0, 8'h21});
        exp_q.push_back({4'd0, 8'h22});
        m_ptr = 0;
        drain_and_compare("stall");

        // uart_tx ignores the first start: one retry, one byte on the line
        clear_bufs();
        begin_batch();
        ignore_next = 1'b1;
        push_byte(0, 8'hA5, 1'b1);
        drive();
        build_expected();
        drain_and_compare("retry");
        check_eq("retry_pulses", 32'(pulse_cnt), 32'd2);
        if (pulse_t.size() >= 2)
            check_eq("retry_gap", 32'(pulse_t[1] - pulse_t[0]), 32'(RT));
        else
            check_eq("retry_gap_missing", 32'(pulse_t.size()), 32'd2);

        // Reset while the UART is busy on a byte
        busy_min = 40;
        busy_max = 40;
        clear_bufs();
        push_byte(1, 8'h31, 1'b0);
        push_byte(1, 8'h32, 1'b1);
        drive();
        guard = 0;
        while (!tx_busy && guard < 50) begin
            step();
            guard++;
        end
        check_eq("rstmid_busy_seen", 32'(tx_busy), 32'd1);
        repeat (3) step();
        #2;
        rst_n    = 1'b0;
        cur_live = 1'b0;
        prev_acc = '0;
        #1;
        check_eq("rstmid_grant", 32'(grant), 32'd0);
        check_eq("rstmid_tx_start", 32'(tx_start), 32'd0);
        check_eq("rstmid_req_ready", 32'(req_ready), 32'd0);
        clear_bufs();
        guard = 0;
        while (tx_busy && guard < 100) begin
            step();
            guard++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = N - 1;
        busy_min = 2;
        busy_max = 5;
        push_byte(1, 8'h41, 1'b1);
        push_byte(0, 8'h51, 1'b1);
        drive();
        begin_batch();
        build_expected();
        drain_and_compare("rstmid");
        if (sent_q.size() > 0)
            check_eq("rstmid_first_src", 32'(sent_q[0][11:8]), 32'd0);
        else
            check_eq("rstmid_nothing_sent", 32'(sent_q.size()), 32'd2);

        // Randomized packets from all sources with mid-packet gaps
        gap_pct  = 30;
        busy_min = 1;
        busy_max = 8;
        for (int r = 0; r < 6; r++) begin
            clear_bufs();
            for (int s = 0; s < N; s++) begin
                int npk = int'($urandom_range(3));
                for (int p = 0; p < npk; p++) begin
                    int len = int'($urandom_range(4, 1));
                    for (int b = 0; b < len; b++)
                        push_byte(s, 8'($urandom), b == len - 1);
                end
            end
            drive();
            begin_batch();
            build_expected();
            drain_and_compare("rand");
            check_eq("rand_pulses", 32'(pulse_cnt), 32'(exp_q.size()));
            check_eq("rand_grant_released", 32'(grant), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
